// File: rtl/multiplier_seq.sv
// rtl/multiplier_seq.sv - iterative shift-add multiplier, signed or unsigned
//
// Produces a 2*WIDTH-bit product from two WIDTH-bit operands, one shift-add
// step per cycle. This is the multiply counterpart of the sequential divider,
// and it uses the same run/stall handshake.
// Optional build macro MUL_RADIX4_EN: chains two steps per cycle, which halves
// the latency. The results are bit-identical to the one-step build.
//
// Ports:
//   clk    in   1        system clock, rising edge
//   rst    in   1        synchronous active-high reset
//   run    in   1        multiply requested; held high for the whole operation
//   u      in   1        1 = unsigned operands, 0 = two's-complement signed
//   x      in   WIDTH    multiplicand, stable while run is high
//   y      in   WIDTH    multiplier, stable while run is high
//   stall  out  1        processor must hold; low once the product is ready
//   z      out  2*WIDTH  product, valid while run=1 and stall=0

module multiplier_seq #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic               u,
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
  output logic               stall,
  output logic [2*WIDTH-1:0] z
);

`ifdef MUL_RADIX4_EN
  localparam logic [5:0] LAST = 6'd16;
`else
  localparam logic [5:0] LAST = 6'd32;
`endif

  logic [5:0]         step_cnt;
  logic [2*WIDTH-1:0] p_q;
  logic [2*WIDTH-1:0] p_in;
  logic [2*WIDTH-1:0] p_next;
  logic               sign_sub;

  // One radix-2 step. {sum, lo} is shifted right by one. The sum is
  // WIDTH+1 bits wide, so the shift keeps the sign bit of the partial
  // product. When sub is set, the multiplicand is subtracted instead of
  // added, because the multiplier MSB has negative weight in signed mode.
  function automatic logic [2*WIDTH-1:0] mul_step(
    input logic [2*WIDTH-1:0] p,
    input logic [WIDTH-1:0]   mcand,
    input logic               uns,
    input logic               sub
  );
    logic [WIDTH:0] w;
    logic [WIDTH:0] h;
    logic [WIDTH:0] sum;
    w   = p[0] ? {~uns & mcand[WIDTH-1], mcand} : '0;
    h   = {~uns & p[2*WIDTH-1], p[2*WIDTH-1:WIDTH]};
    sum = sub ? h - w : h + w;
    return {sum, p[WIDTH-1:1]};
  endfunction

  // In the first run cycle the operand is loaded directly into the datapath,
  // so the first step does not cost an extra cycle.
  always_comb begin
    p_in     = (step_cnt == 6'd0) ? {{WIDTH{1'b0}}, y} : p_q;
    sign_sub = ~u & (step_cnt == LAST - 6'd1);
  end

`ifdef MUL_RADIX4_EN
  logic [2*WIDTH-1:0] p_half;

  // Only the second half-step of the final cycle handles the multiplier MSB.
  always_comb begin
    p_half = mul_step(p_in, x, u, 1'b0);
    p_next = mul_step(p_half, x, u, sign_sub);
  end
`else
  always_comb begin
    p_next = mul_step(p_in, x, u, sign_sub);
  end
`endif

  // The counter saturates at LAST, so the product holds while run stays high.
  // A cycle with run low re-arms the counter for the next operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      step_cnt <= 6'd0;
      p_q      <= '0;
    end else begin
      if (run) begin
        step_cnt <= (step_cnt == LAST) ? LAST : step_cnt + 6'd1;
      end else begin
        step_cnt <= 6'd0;
      end
      if (run && step_cnt != LAST) begin
        p_q <= p_next;
      end
    end
  end

  assign stall = run & (step_cnt != LAST);
  assign z     = p_q;

endmodule
